regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x8 register file and shares it between two writeback requesters: ALU (data plus 7-bit flags) and the load unit (data only).
- Round-robin arbitration with valid/ready handshakes; winner registered into a one-entry write stage that drives the register file write inputs.
- Tracks the write stage and the previous write as in-flight entries.
- Produces a read-after-write interlock (rd_stall) for the decode stage, because register file reads are combinational and writes land on the clock edge.

Parameters:
- AW, 8, address width on all ports; only bits [4:0] select a register.
- DW, 8, data width.
- FW, 7, flag width.
- FLAG_REG, 3, register index that receives flags on an ALU flag write.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle (combinational)
- alu_addr  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_flags  in  FW  ALU flags
- alu_flag_en  in  1  ALU request also updates FLAG_REG
- ld_valid  in  1  load writeback request
- ld_ready  out  1  load request accepted this cycle (combinational)
- ld_addr  in  AW  load destination register
- ld_data  in  DW  loaded data
- wr_en  out  1  register file write enable (registered)
- wr_addr  out  AW  register file write address (registered)
- wr_data  out  DW  register file write data (registered)
- wr_flags  out  FW  register file flag input (registered)
- rd_req  in  1  decode stage intends to read
- rd_a1  in  AW  read address 1
- rd_a2  in  AW  read address 2
- rd_en  out  1  register file read enable = rd_req & ~rd_stall (combinational)
- rd_stall  out  1  read hazard, decode must hold (combinational)

Behaviour:
- Reset: wr_en=0, wr_addr=0, wr_data=0, wr_flags=0, flag-write bit=0, history entry invalid, rr_last=1 (load), so the ALU wins first contention.
- Arbitration, each cycle:
  - Only one valid requester: it is granted.
  - Both valid: grant the one not equal to rr_last.
  - rr_last updates only on a grant.
  - At most one of alu_ready and ld_ready is high per cycle.
  - Ready never asserts without the matching valid.
  - While rst=1, both ready outputs are 0.
- Handshake:
  - A transfer occurs when valid & ready.
  - Requesters hold addr, data and flags stable while valid is high and ready is low.
  - Dropping valid before a grant is permitted; nothing is written.
- Write stage:
  - A transfer at edge N drives wr_en=1 and the winner's fields during cycle N..N+1.
  - The register file captures at edge N+1, giving one cycle from accept to write.
  - No transfer gives wr_en=0 next cycle; wr_addr and wr_data hold their last values.
  - The write stage never back-pressures; one grant per cycle sustains full throughput.
- Flags:
  - ALU win with alu_flag_en=1: wr_flags=alu_flags, internal flag_wr=1.
  - ALU win with alu_flag_en=0: wr_flags holds the previous value, flag_wr=0.
  - Load win: flag_wr=0, wr_flags holds.
  - ALU writing to FLAG_REG with flag_en=1: flags win at FLAG_REG. The interlock treats it as a single write.
- History entry: on every edge, it captures {wr_en, wr_addr[4:0], flag_wr} from the write stage, covering register file write settle time.
- Interlock:
  - rd_stall = rd_req & (hit on rd_a1[4:0] or rd_a2[4:0]).
  - A hit is a match against any of:
    - the write stage address, while wr_en=1
    - FLAG_REG, while the write stage has flag_wr=1
    - the history entry address or flag write under the same rules
    - the address of a transfer accepted this cycle (including FLAG_REG if ALU with flag_en)
  - rd_stall is 0 when rd_req=0.
- Address bits [7:5] are ignored everywhere, including comparisons. For example, addr 0x23 aliases register 3.
- Reset mid-operation: a pending write-stage entry is discarded (wr_en=0 next cycle) and the history is invalidated. A request accepted in the reset cycle is dropped.

Test Plan:
- Reset, then alu_valid=1 with addr=5, data=0xA5, flag_en=1, flags=0x55 -> alu_ready=1 the same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xA5, wr_flags=0x55; following cycle wr_en=0.
- ALU and load both valid for 4 cycles -> grants alternate ALU, LD, ALU, LD; ready outputs never both high; four consecutive wr_en=1 cycles.
- Load to register 7 accepted; rd_req=1, rd_a1=7 -> rd_stall=1 for the accept cycle, write-stage cycle and history cycle (3 cycles), then 0 and rd_en=1.
- ALU with flag_en=1 to register 9, decode reads rd_a2=3 -> rd_stall=1. ALU with flag_en=0, same read -> no stall.
- ld_addr=0x27 accepted, read rd_a1=0x07 -> stall. wr_addr is driven as 0x27; the register file writes register 7.
- rst asserted the cycle after an accept -> wr_en=0 next cycle, rd_stall=0 for rd_a1 equal to that address, and the ALU wins the first contention after reset.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin ALU/load arbiter for the register file write port, with a registered write stage, one-entry write history and read-after-write stall
module regfile_wb_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int FW = 7,
  parameter int FLAG_REG = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic [FW-1:0] alu_flags,
  input  logic          alu_flag_en,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [FW-1:0] wr_flags,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_a1,
  input  logic [AW-1:0] rd_a2,
  output logic          rd_en,
  output logic          rd_stall
);
  localparam logic [4:0] FR = 5'(FLAG_REG);
  logic       r_rr_last;
  logic       r_flag_wr;
  logic       r_h_en;
  logic       r_h_flag;
  logic [4:0] r_h_addr;
  function automatic logic hit(input logic [4:0] a,
                               input logic s_en, input logic [4:0] s_addr, input logic s_flag,
                               input logic h_en, input logic [4:0] h_addr, input logic h_flag,
                               input logic a_rdy, input logic [4:0] a_addr, input logic a_fen,
                               input logic l_rdy, input logic [4:0] l_addr);
    return (s_en && s_addr == a) || (h_en && h_addr == a) ||
           ((s_flag || h_flag) && a == FR) ||
           (a_rdy && (a_addr == a || (a_fen && a == FR))) ||
           (l_rdy && l_addr == a);
  endfunction
  assign alu_ready = ~rst & alu_valid & (~ld_valid | r_rr_last);
  assign ld_ready  = ~rst & ld_valid & (~alu_valid | ~r_rr_last);
  assign rd_stall  = rd_req & (
    hit(rd_a1[4:0], wr_en, wr_addr[4:0], r_flag_wr, r_h_en, r_h_addr, r_h_flag,
        alu_ready, alu_addr[4:0], alu_flag_en, ld_ready, ld_addr[4:0]) |
    hit(rd_a2[4:0], wr_en, wr_addr[4:0], r_flag_wr, r_h_en, r_h_addr, r_h_flag,
        alu_ready, alu_addr[4:0], alu_flag_en, ld_ready, ld_addr[4:0]));
  assign rd_en = rd_req & ~rd_stall;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_flags  <= '0;
      r_flag_wr <= 1'b0;
      r_h_en    <= 1'b0;
      r_h_addr  <= '0;
      r_h_flag  <= 1'b0;
      r_rr_last <= 1'b1;
    end else begin
      wr_en     <= alu_ready | ld_ready;
      r_flag_wr <= alu_ready & alu_flag_en;
      r_h_en    <= wr_en;
      r_h_addr  <= wr_addr[4:0];
      r_h_flag  <= r_flag_wr;
      if (alu_ready) begin
        wr_addr   <= alu_addr;
        wr_data   <= alu_data;
        r_rr_last <= 1'b0;
        if (alu_flag_en) wr_flags <= alu_flags;
      end else if (ld_ready) begin
        wr_addr   <= ld_addr;
        wr_data   <= ld_data;
        r_rr_last <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with a write scoreboard drained by a write-port monitor
module tb_regfile_wb_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       alu_valid, alu_ready, alu_flag_en;
  logic [7:0] alu_addr, alu_data;
  logic [6:0] alu_flags;
  logic       ld_valid, ld_ready;
  logic [7:0] ld_addr, ld_data;
  logic       wr_en;
  logic [7:0] wr_addr, wr_data;
  logic [6:0] wr_flags;
  logic       rd_req, rd_en, rd_stall;
  logic [7:0] rd_a1, rd_a2;
  typedef struct packed {logic [7:0] a; logic [7:0] d; logic [6:0] f;} wr_t;
  wr_t q[$];
  wr_t e;
  int checks = 0;
  int errors = 0;
  logic [6:0] m_flags;
  always #5 clk = ~clk;
  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
    .alu_data(alu_data), .alu_flags(alu_flags), .alu_flag_en(alu_flag_en),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_flags(wr_flags),
    .rd_req(rd_req), .rd_a1(rd_a1), .rd_a2(rd_a2), .rd_en(rd_en), .rd_stall(rd_stall)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    alu_valid = 0;
    ld_valid = 0;
    rd_req = 0;
    repeat (n) cyc();
  endtask
  task automatic alu(input logic [7:0] a, input logic [7:0] d, input logic fe, input logic [6:0] f);
    alu_valid = 1;
    alu_addr = a;
    alu_data = d;
    alu_flag_en = fe;
    alu_flags = f;
  endtask
  task automatic ld(input logic [7:0] a, input logic [7:0] d);
    ld_valid = 1;
    ld_addr = a;
    ld_data = d;
  endtask
  task automatic push(input logic [7:0] a, input logic [7:0] d);
    q.push_back({a, d, m_flags});
  endtask
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got write addr %0h data %0h, expected none", wr_addr, wr_data);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
        chk("wr_flags", 32'(wr_flags), 32'(e.f));
      end
    end
  end
  initial begin
    rst = 1;
    alu_valid = 1; alu_addr = 0; alu_data = 0; alu_flags = 0; alu_flag_en = 0;
    ld_valid = 1; ld_addr = 0; ld_data = 0;
    rd_req = 0; rd_a1 = 0; rd_a2 = 0;
    m_flags = 0;
    cyc();
    cyc();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_wr_flags", 32'(wr_flags), 0);
    chk("rst_alu_ready", 32'(alu_ready), 0);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    rst = 0;
    idle(1);
    alu(8'h05, 8'hA5, 1, 7'h55);
    #1;
    chk("t1_alu_ready", 32'(alu_ready), 1);
    chk("t1_ld_ready", 32'(ld_ready), 0);
    m_flags = 7'h55;
    push(8'h05, 8'hA5);
    cyc();
    alu_valid = 0;
    #1;
    chk("t1_wr_en_1", 32'(wr_en), 1);
    cyc();
    chk("t1_wr_en_0", 32'(wr_en), 0);
    idle(2);
    ld(8'h07, 8'h77);
    rd_req = 1; rd_a1 = 8'h07; rd_a2 = 8'h14;
    #1;
    chk("t3_ld_ready", 32'(ld_ready), 1);
    chk("t3_stall_accept", 32'(rd_stall), 1);
    push(8'h07, 8'h77);
    cyc();
    ld_valid = 0;
    #1;
    chk("t3_stall_stage", 32'(rd_stall), 1);
    cyc();
    chk("t3_stall_hist", 32'(rd_stall), 1);
    cyc();
    chk("t3_stall_clear", 32'(rd_stall), 0);
    chk("t3_rd_en", 32'(rd_en), 1);
    idle(2);
    alu(8'h0A, 8'h10, 0, 7'h00);
    ld(8'h0B, 8'h11);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_alu_ready", 32'(alu_ready), (i % 2 == 0) ? 1 : 0);
      chk("t2_ld_ready", 32'(ld_ready), (i % 2 == 0) ? 0 : 1);
      if (i > 0) chk("t2_wr_en", 32'(wr_en), 1);
      if (i % 2 == 0) push(8'h0A, 8'h10);
      else push(8'h0B, 8'h11);
      cyc();
    end
    alu_valid = 0;
    ld_valid = 0;
    #1;
    chk("t2_wr_en_last", 32'(wr_en), 1);
    cyc();
    chk("t2_wr_en_off", 32'(wr_en), 0);
    idle(2);
    alu(8'h09, 8'h99, 1, 7'h2A);
    rd_req = 1; rd_a1 = 8'h14; rd_a2 = 8'h03;
    #1;
    chk("t4_flag_stall", 32'(rd_stall), 1);
    chk("t4_rd_en", 32'(rd_en), 0);
    m_flags = 7'h2A;
    push(8'h09, 8'h99);
    cyc();
    alu_valid = 0;
    #1;
    chk("t4_flag_stall_stage", 32'(rd_stall), 1);
    idle(2);
    alu(8'h09, 8'h98, 0, 7'h7F);
    rd_req = 1; rd_a1 = 8'h14; rd_a2 = 8'h03;
    #1;
    chk("t4_noflag_ready", 32'(alu_ready), 1);
    chk("t4_noflag_stall", 32'(rd_stall), 0);
    push(8'h09, 8'h98);
    cyc();
    alu_valid = 0;
    #1;
    chk("t4_noflag_stall_stage", 32'(rd_stall), 0);
    idle(2);
    ld(8'h27, 8'h5C);
    rd_req = 1; rd_a1 = 8'h07; rd_a2 = 8'h14;
    #1;
    chk("t5_alias_stall", 32'(rd_stall), 1);
    push(8'h27, 8'h5C);
    cyc();
    ld_valid = 0;
    rd_req = 0;
    #1;
    chk("t5_noreq_stall", 32'(rd_stall), 0);
    chk("t5_noreq_rd_en", 32'(rd_en), 0);
    idle(2);
    alu(8'h0C, 8'hC3, 0, 7'h00);
    #1;
    chk("t6_accept", 32'(alu_ready), 1);
    push(8'h0C, 8'hC3);
    cyc();
    rst = 1;
    alu(8'h0D, 8'hD0, 0, 7'h00);
    ld(8'h0E, 8'hE0);
    #1;
    chk("t6_rst_alu_ready", 32'(alu_ready), 0);
    chk("t6_rst_ld_ready", 32'(ld_ready), 0);
    cyc();
    rst = 0;
    alu_valid = 0;
    ld_valid = 0;
    rd_req = 1; rd_a1 = 8'h0C; rd_a2 = 8'h14;
    m_flags = 0;
    #1;
    chk("t6_wr_en_after_rst", 32'(wr_en), 0);
    chk("t6_stall_after_rst", 32'(rd_stall), 0);
    chk("t6_wr_flags_after_rst", 32'(wr_flags), 0);
    cyc();
    rd_req = 0;
    alu(8'h01, 8'h01, 0, 7'h00);
    ld(8'h02, 8'h02);
    #1;
    chk("t6_first_alu", 32'(alu_ready), 1);
    chk("t6_first_ld", 32'(ld_ready), 0);
    push(8'h01, 8'h01);
    cyc();
    idle(3);
    chk("sb_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
